// File: rtl/collision_pair_calc_if.sv
// Bus bundle for collision_pair_calc: frame pulse, ball state vectors and
// the tagged result broadcast seen by the per-pair collision detectors.
interface collision_pair_calc_if #(
   parameter int unsigned NUM_BALLS = 6
);
   logic                       startOfFrame;
   logic [NUM_BALLS-1:0][31:0] balls_x;
   logic [NUM_BALLS-1:0][31:0] balls_y;
   logic [NUM_BALLS-1:0][31:0] balls_vx;
   logic [NUM_BALLS-1:0][31:0] balls_vy;
   logic [31:0]                inter_x;
   logic [31:0]                inter_y;
   logic [31:0]                AB_squre_dist;
   logic [31:0]                AB_nxt_squre_dist;
   logic [3:0]                 collision_select;
   logic                       busy;
   logic                       sweep_done;
   logic                       overrun;

   modport master (
      output startOfFrame, balls_x, balls_y, balls_vx, balls_vy,
      input  inter_x, inter_y, AB_squre_dist, AB_nxt_squre_dist,
             collision_select, busy, sweep_done, overrun
   );

   modport slave (
      input  startOfFrame, balls_x, balls_y, balls_vx, balls_vy,
      output inter_x, inter_y, AB_squre_dist, AB_nxt_squre_dist,
             collision_select, busy, sweep_done, overrun
   );
endinterface

// File: rtl/collision_pair_calc.sv
// Shared, time-multiplexed pair arithmetic for the ball collision detectors.
// Snapshots all balls on startOfFrame, walks every pair (i<j) through a
// 3-stage pipeline and broadcasts the tagged results one pair per cycle.
// Optional macro COLLISION_CALC_SATURATE_EN: saturate the 64->32 narrowing
// instead of keeping the low 32 bits.
module collision_pair_calc #(
   parameter int unsigned NUM_BALLS = 6,
   parameter logic [3:0]  IDLE_SEL  = 4'hF
) (
   input logic                  clk,
   input logic                  reset,
   collision_pair_calc_if.slave bus
);
   localparam int unsigned NUM_PAIRS = NUM_BALLS * (NUM_BALLS - 1) / 2;
   localparam int unsigned IW        = $clog2(NUM_BALLS);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t             state;
   logic [IW-1:0]      a_idx, b_idx;
   logic [3:0]         k;
   logic               busy_q, done_q, overrun_q;

   logic signed [31:0] snap_x  [NUM_BALLS];
   logic signed [31:0] snap_y  [NUM_BALLS];
   logic signed [31:0] snap_vx [NUM_BALLS];
   logic signed [31:0] snap_vy [NUM_BALLS];

   logic signed [32:0] abx, aby, abvx, abvy;
   logic signed [33:0] nxx, nxy;

   logic               s1_valid;
   logic [3:0]         s1_k;
   logic signed [32:0] s1_abx, s1_aby, s1_abvx, s1_abvy;
   logic signed [33:0] s1_nxx, s1_nxy;

   logic               s2_valid;
   logic [3:0]         s2_k;
   logic signed [63:0] s2_dot, s2_d, s2_n, s2_abx, s2_aby;

   logic [31:0]        inter_x_q, inter_y_q, dist_q, nxt_dist_q;
   logic [3:0]         sel_q;

   function automatic logic [31:0] narrow(input logic signed [63:0] v);
`ifdef COLLISION_CALC_SATURATE_EN
      if (v > 64'sd2147483647)
         return 32'h7FFF_FFFF;
      else if (v < -64'sd2147483648)
         return 32'h8000_0000;
      else
         return v[31:0];
`else
      return v[31:0];
`endif
   endfunction

   // Frame snapshot: captured only when an IDLE engine accepts a frame pulse.
   always_ff @(posedge clk) begin
      if (state == IDLE && bus.startOfFrame) begin
         for (int unsigned i = 0; i < NUM_BALLS; i++) begin
            snap_x[i]  <= bus.balls_x[i];
            snap_y[i]  <= bus.balls_y[i];
            snap_vx[i] <= bus.balls_vx[i];
            snap_vy[i] <= bus.balls_vy[i];
         end
      end
   end

   // Sweep sequencer: pair enumeration, busy/done/overrun flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         a_idx     <= '0;
         b_idx     <= '0;
         k         <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (bus.startOfFrame && state != IDLE)
            overrun_q <= 1'b1;
         unique case (state)
            IDLE: begin
               if (bus.startOfFrame) begin
                  a_idx  <= '0;
                  b_idx  <= IW'(1);
                  k      <= '0;
                  busy_q <= 1'b1;
                  state  <= ISSUE;
               end
            end
            ISSUE: begin
               // Row-major walk of the upper triangle: B runs to N-1, then A steps.
               if (b_idx == IW'(NUM_BALLS - 1)) begin
                  a_idx <= a_idx + IW'(1);
                  b_idx <= a_idx + IW'(2);
               end else begin
                  b_idx <= b_idx + IW'(1);
               end
               k <= k + 4'd1;
               if (k == 4'(NUM_PAIRS - 1))
                  state <= DRAIN;
            end
            DRAIN: begin
               // Last pair is in the output register once S1 and S2 are empty.
               if (!s1_valid && !s2_valid) begin
                  done_q <= 1'b1;
                  state  <= DONE;
               end
            end
            DONE: begin
               busy_q <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   // Operand fetch and differences for the pair currently being issued.
   always_comb begin
      abx  = {snap_x[a_idx][31],  snap_x[a_idx]}  - {snap_x[b_idx][31],  snap_x[b_idx]};
      aby  = {snap_y[a_idx][31],  snap_y[a_idx]}  - {snap_y[b_idx][31],  snap_y[b_idx]};
      abvx = {snap_vx[a_idx][31], snap_vx[a_idx]} - {snap_vx[b_idx][31], snap_vx[b_idx]};
      abvy = {snap_vy[a_idx][31], snap_vy[a_idx]} - {snap_vy[b_idx][31], snap_vy[b_idx]};
      nxx  = {abx[32], abx} + {abvx[32], abvx};
      nxy  = {aby[32], aby} + {abvy[32], abvy};
   end

   // S1: register relative position, velocity and next-step position.
   always_ff @(posedge clk) begin
      if (reset)
         s1_valid <= 1'b0;
      else
         s1_valid <= (state == ISSUE);
      s1_k    <= k;
      s1_abx  <= abx;
      s1_aby  <= aby;
      s1_abvx <= abvx;
      s1_abvy <= abvy;
      s1_nxx  <= nxx;
      s1_nxy  <= nxy;
   end

   // S2: 64-bit dot product and both squared distances.
   always_ff @(posedge clk) begin
      if (reset)
         s2_valid <= 1'b0;
      else
         s2_valid <= s1_valid;
      s2_k   <= s1_k;
      s2_dot <= 64'(s1_abvx) * 64'(s1_abx) + 64'(s1_abvy) * 64'(s1_aby);
      s2_d   <= 64'(s1_abx) * 64'(s1_abx) + 64'(s1_aby) * 64'(s1_aby);
      s2_n   <= 64'(s1_nxx) * 64'(s1_nxx) + 64'(s1_nxy) * 64'(s1_nxy);
      s2_abx <= 64'(s1_abx);
      s2_aby <= 64'(s1_aby);
   end

   // S3: projection numerator, narrowing and tagged broadcast; data holds when idle.
   always_ff @(posedge clk) begin
      if (reset) begin
         inter_x_q  <= '0;
         inter_y_q  <= '0;
         dist_q     <= '0;
         nxt_dist_q <= '0;
         sel_q      <= IDLE_SEL;
      end else if (s2_valid) begin
         inter_x_q  <= narrow(s2_dot * s2_abx);
         inter_y_q  <= narrow(s2_dot * s2_aby);
         dist_q     <= narrow(s2_d);
         nxt_dist_q <= narrow(s2_n);
         sel_q      <= s2_k;
      end else begin
         sel_q      <= IDLE_SEL;
      end
   end

   assign bus.inter_x           = inter_x_q;
   assign bus.inter_y           = inter_y_q;
   assign bus.AB_squre_dist     = dist_q;
   assign bus.AB_nxt_squre_dist = nxt_dist_q;
   assign bus.collision_select  = sel_q;
   assign bus.busy              = busy_q;
   assign bus.sweep_done        = done_q;
   assign bus.overrun           = overrun_q;
endmodule

// File: tb/tb_collision_pair_calc.sv
// Self-checking bench for collision_pair_calc: a 2-ball instance for the
// directed arithmetic cases and a 6-ball instance for randomized sweeps
// compared against a pair-enumerating reference model.
`timescale 1ns/1ps
module tb_collision_pair_calc;
   localparam int N = 6;
   localparam int P = N * (N - 1) / 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   collision_pair_calc_if #(.NUM_BALLS(6)) bus6 ();
   collision_pair_calc_if #(.NUM_BALLS(2)) bus2 ();

   collision_pair_calc #(.NUM_BALLS(6), .IDLE_SEL(4'hF)) u6 (
      .clk(clk), .reset(reset), .bus(bus6.slave));
   collision_pair_calc #(.NUM_BALLS(2), .IDLE_SEL(4'hF)) u2 (
      .clk(clk), .reset(reset), .bus(bus2.slave));

   int checks   = 0;
   int failures = 0;

   longint sx [N];
   longint sy [N];
   longint svx[N];
   longint svy[N];
   logic [31:0] last_ix, last_iy, last_d, last_n;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
      end
   endtask

   function automatic logic [31:0] narrow(input longint v);
`ifdef COLLISION_CALC_SATURATE_EN
      if (v > 64'sd2147483647) return 32'h7FFF_FFFF;
      if (v < -64'sd2147483648) return 32'h8000_0000;
`endif
      return v[31:0];
   endfunction

   // Reference: find the k-th (i<j) pair and evaluate the formulas directly.
   task automatic model_pair(input int k, output logic [31:0] ix, output logic [31:0] iy,
                             output logic [31:0] d, output logic [31:0] n);
      int cnt, a, b;
      longint dx, dy, dvx, dvy, dot;
      cnt = 0; a = 0; b = 0;
      for (int i = 0; i < N; i++)
         for (int j = i + 1; j < N; j++) begin
            if (cnt == k) begin a = i; b = j; end
            cnt++;
         end
      dx  = sx[a] - sx[b];
      dy  = sy[a] - sy[b];
      dvx = svx[a] - svx[b];
      dvy = svy[a] - svy[b];
      dot = dvx * dx + dvy * dy;
      ix  = narrow(dot * dx);
      iy  = narrow(dot * dy);
      d   = narrow(dx * dx + dy * dy);
      n   = narrow((dx + dvx) * (dx + dvx) + (dy + dvy) * (dy + dvy));
   endtask

   function automatic logic [31:0] rnd(input int bits);
      int r;
      r = $urandom;
      return 32'(r >>> (31 - bits));
   endfunction

   task automatic randomize_balls(input int pbits, input int vbits);
      for (int i = 0; i < N; i++) begin
         bus6.balls_x[i]  = rnd(pbits);
         bus6.balls_y[i]  = rnd(pbits);
         bus6.balls_vx[i] = rnd(vbits);
         bus6.balls_vy[i] = rnd(vbits);
      end
   endtask

   task automatic take_snapshot();
      for (int i = 0; i < N; i++) begin
         sx[i]  = longint'($signed(bus6.balls_x[i]));
         sy[i]  = longint'($signed(bus6.balls_y[i]));
         svx[i] = longint'($signed(bus6.balls_vx[i]));
         svy[i] = longint'($signed(bus6.balls_vy[i]));
      end
   endtask

   // One frame on the 6-ball engine; cycle c is the c-th cycle after the frame edge.
   task automatic sweep6(input bit change_mid, input bit extra_sof, input int abort_at,
                         input bit ovr_in);
      logic [31:0] ix, iy, d, n;
      bit ovr;
      int sel_exp;
      ovr = ovr_in;
      @(negedge clk);
      bus6.startOfFrame = 1'b1;
      take_snapshot();
      @(negedge clk);
      bus6.startOfFrame = 1'b0;
      for (int c = 1; c <= P + 6; c++) begin
         if (abort_at > 0 && c > abort_at) begin
            if (c == abort_at + 1) begin
               chk("rst_busy", 32'(bus6.busy), 32'd0);
               chk("rst_ovr", 32'(bus6.overrun), 32'd0);
               chk("rst_ix", bus6.inter_x, 32'd0);
               chk("rst_d", bus6.AB_squre_dist, 32'd0);
               last_ix = '0; last_iy = '0; last_d = '0; last_n = '0;
               reset = 1'b0;
            end
            chk("abort_sel", 32'(bus6.collision_select), 32'hF);
            chk("abort_done", 32'(bus6.sweep_done), 32'd0);
         end else begin
            sel_exp = (c >= 4 && c < 4 + P) ? c - 4 : 15;
            chk("sel", 32'(bus6.collision_select), 32'(sel_exp));
            chk("busy", 32'(bus6.busy), 32'(c <= P + 4));
            chk("done", 32'(bus6.sweep_done), 32'(c == P + 4));
            chk("overrun", 32'(bus6.overrun), 32'(ovr));
            if (sel_exp != 15) begin
               model_pair(sel_exp, ix, iy, d, n);
               last_ix = ix; last_iy = iy; last_d = d; last_n = n;
            end
            chk("inter_x", bus6.inter_x, last_ix);
            chk("inter_y", bus6.inter_y, last_iy);
            chk("dist", bus6.AB_squre_dist, last_d);
            chk("nxt_dist", bus6.AB_nxt_squre_dist, last_n);
         end
         if (change_mid && c == 2) randomize_balls(20, 10);
         if (extra_sof && c == 3) begin bus6.startOfFrame = 1'b1; ovr = 1'b1; end
         if (c == 4) bus6.startOfFrame = 1'b0;
         if (abort_at > 0 && c == abort_at) reset = 1'b1;
         @(negedge clk);
      end
   endtask

   // Directed 2-ball frame with explicit expected outputs at T+4.
   task automatic frame2(input string tag, input logic [31:0] ix, input logic [31:0] iy,
                         input logic [31:0] d, input logic [31:0] n);
      @(negedge clk);
      bus2.startOfFrame = 1'b1;
      @(negedge clk);
      bus2.startOfFrame = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         chk({tag, "_sel"}, 32'(bus2.collision_select), (c == 4) ? 32'd0 : 32'hF);
         chk({tag, "_done"}, 32'(bus2.sweep_done), 32'(c == 5));
         if (c == 4) begin
            chk({tag, "_ix"}, bus2.inter_x, ix);
            chk({tag, "_iy"}, bus2.inter_y, iy);
            chk({tag, "_d"}, bus2.AB_squre_dist, d);
            chk({tag, "_n"}, bus2.AB_nxt_squre_dist, n);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      reset = 1'b1;
      bus6.startOfFrame = 1'b0;
      bus2.startOfFrame = 1'b0;
      bus6.balls_x = '0; bus6.balls_y = '0; bus6.balls_vx = '0; bus6.balls_vy = '0;
      bus2.balls_x = '0; bus2.balls_y = '0; bus2.balls_vx = '0; bus2.balls_vy = '0;
      last_ix = '0; last_iy = '0; last_d = '0; last_n = '0;
      repeat (3) @(negedge clk);
      chk("reset_sel", 32'(bus6.collision_select), 32'hF);
      chk("reset_busy", 32'(bus6.busy), 32'd0);
      chk("reset_done", 32'(bus6.sweep_done), 32'd0);
      chk("reset_ovr", 32'(bus6.overrun), 32'd0);
      chk("reset_ix", bus6.inter_x, 32'd0);
      chk("reset_n", bus6.AB_nxt_squre_dist, 32'd0);
      reset = 1'b0;

      // A=(0,0) v(10,0); B=(2048,0) v(0,0)
      bus2.balls_vx[0] = 32'd10;
      bus2.balls_x[1]  = 32'd2048;
      frame2("two", 32'd41943040, 32'd0, 32'd4194304, 32'd4153444);

      // A=(0,0), B=(40960,40960), at rest: squared distance exceeds 32 bits
      bus2.balls_vx = '0;
      bus2.balls_x[1] = 32'd40960;
      bus2.balls_y[1] = 32'd40960;
`ifdef COLLISION_CALC_SATURATE_EN
      frame2("sat", 32'd0, 32'd0, 32'd2147483647, 32'd2147483647);
`else
      frame2("wrap", 32'd0, 32'd0, 32'hC800_0000, 32'hC800_0000);
`endif

      randomize_balls(20, 10);
      sweep6(1'b0, 1'b0, 0, 1'b0);
      randomize_balls(31, 31);
      sweep6(1'b0, 1'b0, 0, 1'b0);
      randomize_balls(20, 10);
      sweep6(1'b1, 1'b0, 0, 1'b0);
      randomize_balls(24, 12);
      sweep6(1'b0, 1'b1, 0, 1'b0);
      randomize_balls(20, 10);
      sweep6(1'b0, 1'b0, 0, 1'b1);
      randomize_balls(20, 10);
      sweep6(1'b0, 1'b0, 6, 1'b1);
      randomize_balls(20, 10);
      sweep6(1'b0, 1'b0, 0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
